// File: rtl/keyboard_fifo_ctrl_if.sv
// Keyboard controller bus: character source, CPU-side KBSR/KBDR access
// and the interrupt line. The master drives the strobes and data; the slave
// (the controller) returns status, data and interrupt.
interface keyboard_fifo_ctrl_if #(
   parameter int DATA_W = 8
);
   logic [31:0]       data_in;
   logic [DATA_W-1:0] ASCII;
   logic              LD_ASCII;
   logic              LD_KBSR;
   logic              RD_KBDR;
   logic [31:0]       KBSR;
   logic [31:0]       KBDR;
   logic              KB_INT;

   modport master (
      output data_in, ASCII, LD_ASCII, LD_KBSR, RD_KBDR,
      input  KBSR, KBDR, KB_INT
   );

   modport slave (
      input  data_in, ASCII, LD_ASCII, LD_KBSR, RD_KBDR,
      output KBSR, KBDR, KB_INT
   );
endinterface

// File: rtl/keyboard_fifo_ctrl.sv
// Keyboard input controller: a DEPTH-entry receive FIFO ahead of the
// CPU-visible KBDR, a KBSR status/control register with occupancy, full
// and sticky overflow flags, and a level interrupt on occupancy threshold
// or overflow.
module keyboard_fifo_ctrl #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   keyboard_fifo_ctrl_if.slave  bus
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;
   logic              ovf_q,    ovf_d;
   logic              ie_q,     ie_d;
   logic              oie_q,    oie_d;
   logic [7:0]        thresh_q, thresh_d;

   logic              rdy;
   logic              full;
   logic              push;
   logic              pop;
   logic              ovf_set;
   logic [7:0]        eff_th;
   logic [7:0]        count8;

   // Bits of data_in that carry no writable field.
   logic              unused_din;
   assign unused_din = ^{bus.data_in[31:30], bus.data_in[28:16], bus.data_in[13:8]};

   assign rdy     = (count_q != '0);
   assign full    = (count_q == (ADDR_W+1)'(DEPTH));
   // A pop frees a slot in the same cycle, so a full FIFO still accepts
   // a character when the CPU is reading.
   assign pop     = bus.RD_KBDR & rdy;
   assign push    = bus.LD_ASCII & (~full | bus.RD_KBDR);
   assign ovf_set = bus.LD_ASCII & full & ~bus.RD_KBDR;

   // Next-state for pointers, occupancy, overflow flag and control fields.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      ie_d     = ie_q;
      oie_d    = oie_q;
      thresh_d = thresh_q;

      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase

      if (bus.LD_KBSR) begin
         ie_d     = bus.data_in[15];
         oie_d    = bus.data_in[14];
         thresh_d = bus.data_in[7:0];
         if (bus.data_in[29]) ovf_d = 1'b0;
      end
      // A drop in the same cycle as a W1C leaves the flag set.
      if (ovf_set) ovf_d = 1'b1;
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         ie_q     <= 1'b0;
         oie_q    <= 1'b0;
         thresh_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         ie_q     <= ie_d;
         oie_q    <= oie_d;
         thresh_q <= thresh_d;
      end
   end

   // Character storage; contents are qualified by count, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.ASCII;
   end

   assign count8 = 8'(count_q);
   assign eff_th = (thresh_q == 8'd0) ? 8'd1 : thresh_q;

   assign bus.KBSR   = {rdy, full, ovf_q, 5'b0, count8, ie_q, oie_q, 6'b0, thresh_q};
   assign bus.KBDR   = rdy ? 32'(mem_q[rd_ptr_q]) : 32'd0;
   assign bus.KB_INT = (ie_q & (count8 >= eff_th)) | (oie_q & ovf_q);

endmodule

// File: tb/tb_keyboard_fifo_ctrl.sv
// Bench for keyboard_fifo_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_keyboard_fifo_ctrl;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;

   logic clk = 1'b0;
   logic reset;

   keyboard_fifo_ctrl_if #(.DATA_W(DATA_W)) bus ();

   keyboard_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0] m_q[$];
   bit         m_ovf, m_ie, m_oie;
   logic [7:0] m_th;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_kbsr();
      logic [31:0] v;
      int n;
      n = m_q.size();
      v = 32'd0;
      v[31]    = (n != 0);
      v[30]    = (n == DEPTH);
      v[29]    = m_ovf;
      v[23:16] = 8'(n);
      v[15]    = m_ie;
      v[14]    = m_oie;
      v[7:0]   = m_th;
      return v;
   endfunction

   function automatic logic [31:0] exp_kbdr();
      return (m_q.size() != 0) ? {24'd0, m_q[0]} : 32'd0;
   endfunction

   function automatic logic exp_int();
      int th;
      th = (m_th == 0) ? 1 : int'(m_th);
      return (m_ie && m_q.size() >= th) || (m_oie && m_ovf);
   endfunction

   // One clock: drive inputs, advance model, compare all outputs.
   task automatic cycle(input bit ld, input logic [7:0] ch, input bit rd,
                        input bit wr, input logic [31:0] din, input bit rst);
      bit full, empty;
      bus.LD_ASCII = ld;
      bus.ASCII    = ch;
      bus.RD_KBDR  = rd;
      bus.LD_KBSR  = wr;
      bus.data_in  = din;
      reset        = rst;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_ovf = 0; m_ie = 0; m_oie = 0; m_th = 8'd0;
      end else begin
         full  = (m_q.size() == DEPTH);
         empty = (m_q.size() == 0);
         if (rd && !empty) void'(m_q.pop_front());
         if (ld && (!full || rd)) m_q.push_back(ch);
         if (wr) begin
            if (din[29]) m_ovf = 0;
            m_ie  = din[15];
            m_oie = din[14];
            m_th  = din[7:0];
         end
         if (ld && full && !rd) m_ovf = 1;
      end
      #1;
      chk("KBSR",   bus.KBSR,   exp_kbsr());
      chk("KBDR",   bus.KBDR,   exp_kbdr());
      chk("KB_INT", {31'd0, bus.KB_INT}, {31'd0, exp_int()});
   endtask

   task automatic push(input logic [7:0] ch);  cycle(1, ch, 0, 0, 0, 0); endtask
   task automatic rd();                        cycle(0, 0, 1, 0, 0, 0); endtask
   task automatic wr(input logic [31:0] d);    cycle(0, 0, 0, 1, d, 0); endtask
   task automatic rst_cyc();                   cycle(0, 0, 0, 0, 0, 1); endtask

   initial begin
      bus.LD_ASCII = 0; bus.ASCII = 0; bus.RD_KBDR = 0;
      bus.LD_KBSR = 0; bus.data_in = 0; reset = 1;
      m_ovf = 0; m_ie = 0; m_oie = 0; m_th = 0;

      // T1: reset, two pushes, two reads
      rst_cyc();
      chk("T1_reset_kbsr", bus.KBSR, 32'd0);
      push(8'h41); push(8'h42);
      chk("T1_kbsr", bus.KBSR, 32'h8002_0000);
      chk("T1_kbdr0", bus.KBDR, 32'h41);
      rd();
      chk("T1_kbdr1", bus.KBDR, 32'h42);
      rd();
      chk("T1_empty_kbsr", bus.KBSR, 32'd0);
      chk("T1_empty_kbdr", bus.KBDR, 32'd0);
      rd();   // read on empty: no effect

      // T2: fill, overflow, drain in order, W1C
      for (int i = 0; i < DEPTH; i++) push(8'h60 + 8'(i));
      chk("T2_full", bus.KBSR, 32'hC010_0000);
      push(8'hEE);
      chk("T2_ovf", bus.KBSR, 32'hE010_0000);
      for (int i = 0; i < DEPTH; i++) begin
         chk("T2_order", bus.KBDR, 32'h60 + i);
         rd();
      end
      wr(32'h2000_0000);
      chk("T2_w1c", bus.KBSR, 32'd0);

      // T3: threshold interrupt
      wr(32'h0000_8003);
      push(8'h01); push(8'h02);
      chk("T3_int_lo", {31'd0, bus.KB_INT}, 32'd0);
      push(8'h03);
      chk("T3_int_hi", {31'd0, bus.KB_INT}, 32'd1);
      rd();
      chk("T3_int_drop", {31'd0, bus.KB_INT}, 32'd0);
      rd(); rd();

      // T4: simultaneous push+pop when full and when empty
      for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i));
      cycle(1, 8'hA5, 1, 0, 0, 0);
      chk("T4_full_both", bus.KBSR[29:16], {1'b0, 5'd0, 8'd16});
      for (int i = 0; i < DEPTH; i++) rd();
      cycle(1, 8'h77, 1, 0, 0, 0);
      chk("T4_empty_both", bus.KBSR[23:16], 32'd1);
      chk("T4_empty_kbdr", bus.KBDR, 32'h77);
      rd();

      // T5: wrap with push/pop pairs at count 5, then OVF set vs W1C
      for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
      for (int i = 0; i < 40; i++) cycle(1, 8'hC0 + 8'(i), 1, 0, 0, 0);
      for (int i = 0; i < 11; i++) push(8'h20 + 8'(i));
      cycle(1, 8'hFF, 0, 1, 32'h2000_4000, 0);
      chk("T5_ovf_wins", {31'd0, bus.KBSR[29]}, 32'd1);
      chk("T5_oie_int", {31'd0, bus.KB_INT}, 32'd1);

      // T6: reset with live state, then a push
      rst_cyc();
      for (int i = 0; i < 7; i++) push(8'h30 + 8'(i));
      wr(32'h0000_8000);
      chk("T6_int_before", {31'd0, bus.KB_INT}, 32'd1);
      rst_cyc();
      chk("T6_kbsr", bus.KBSR, 32'd0);
      chk("T6_kbdr", bus.KBDR, 32'd0);
      chk("T6_int", {31'd0, bus.KB_INT}, 32'd0);
      push(8'h5A);
      chk("T6_push_kbdr", bus.KBDR, 32'h5A);
      chk("T6_push_cnt", bus.KBSR[23:16], 32'd1);

      // Randomized traffic with phases biased toward filling or draining
      for (int ph = 0; ph < 24; ph++) begin
         int p_ld, p_rd;
         p_ld = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
         p_rd = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
         for (int c = 0; c < 80; c++) begin
            bit ld, r, w, rs;
            logic [31:0] d;
            ld = ($urandom_range(99) < p_ld);
            r  = ($urandom_range(99) < p_rd);
            w  = ($urandom_range(99) < 6);
            rs = ($urandom_range(999) < 4);
            d  = $urandom;
            d[7:0] = 8'($urandom_range(DEPTH + 1));
            cycle(ld, 8'($urandom), r, w, d, rs);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
